// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings and FSM state type for the M-stage data-memory interface.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: picks the addressed byte/half of a read word and sign- or zero-extends it.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] result
);
    logic [15:0] h;
    logic [7:0]  b;
    always_comb begin
        h = byte_off[1] ? rdata[31:16] : rdata[15:0];
        b = byte_off[0] ? h[15:8] : h[7:0];
        result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_BU ? {24'b0, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: RV32I M stage; issues one req/ack data-memory transaction per load/store and
// stalls the pipeline until it completes, flagging misaligned or illegal accesses instead.
module memory_access
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_m_i,
    input  logic                  mem_read_m_i,
    input  logic                  mem_write_m_i,
    input  logic [2:0]            funct3_m_i,
    input  logic [ADDR_WIDTH-1:0] alu_result_m_i,
    input  logic [DATA_WIDTH-1:0] write_data_m_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] read_data_m_o,
    output logic                  stall_o,
    output logic                  fault_o
);
    mem_state_t state, state_nx;
    logic access, bad, start;
    logic [1:0] off, off_q;
    logic [2:0] f3_q;
    logic we_q;
    logic [3:0] be, be_q;
    logic [DATA_WIDTH-1:0] wdata, wdata_q, fmt;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign off = alu_result_m_i[1:0];

    always_comb begin
        access = valid_m_i & (mem_read_m_i | mem_write_m_i);
        bad = (mem_read_m_i & mem_write_m_i)
            | (funct3_m_i == 3'b011) | (funct3_m_i[2:1] == 2'b11)
            | ((funct3_m_i[1:0] == 2'b01) & off[0])
            | ((funct3_m_i == F3_W) & (off != 2'b00));
        fault_o = (state == IDLE) & access & bad;
        start = (state == IDLE) & access & ~bad;
        be = funct3_m_i[1:0] == 2'b00 ? 4'b0001 << off :
             funct3_m_i[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // Stores replicate the right-aligned data into every lane; loads drive zero.
        wdata = !mem_write_m_i ? '0 :
                funct3_m_i[1:0] == 2'b00 ? {4{write_data_m_i[7:0]}} :
                funct3_m_i[1:0] == 2'b01 ? {2{write_data_m_i[15:0]}} : write_data_m_i;
        state_nx = state == IDLE ? (start ? BUSY : IDLE) :
                   state == BUSY ? (dmem_ack_i ? DONE : BUSY) : IDLE;
        stall_o = start | (state == BUSY);
        dmem_req_o = state == BUSY;
        dmem_we_o = dmem_req_o & we_q;
        dmem_addr_o = addr_q;
        dmem_be_o = be_q;
        dmem_wdata_o = wdata_q;
    end

    load_formatter u_fmt (
        .rdata    (dmem_rdata_i),
        .funct3   (f3_q),
        .byte_off (off_q),
        .result   (fmt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr_q <= '0;
            be_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            f3_q <= F3_B;
            off_q <= 2'b00;
            read_data_m_o <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr_q <= {alu_result_m_i[ADDR_WIDTH-1:2], 2'b00};
                be_q <= be;
                wdata_q <= wdata;
                we_q <= mem_write_m_i;
                f3_q <= funct3_m_i;
                off_q <= off;
            end
            if (state == BUSY && dmem_ack_i && !we_q)
                read_data_m_o <= fmt;
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vectors with a queue scoreboard; a negedge monitor checks each
// memory request, completion and fault against expectations pushed by the stimulus.
module tb_memory_access;
    logic clk = 0, rst_n = 0;
    logic valid = 0, rd = 0, wr = 0, ack = 0;
    logic [2:0] f3 = 0;
    logic [31:0] addr = 0, wd = 0, rdata = 0;
    logic req, we, stall, fault;
    logic [31:0] maddr, mwdata, rdout;
    logic [3:0] be;
    int vectors = 0, miscompares = 0;

    typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} req_t;
    req_t req_q[$];
    logic [31:0] rd_q[$], flt_q[$];
    req_t cur;
    logic req_prev = 0;
    logic [31:0] last_rd = 0;

    memory_access dut (
        .clk(clk), .rst_n(rst_n), .valid_m_i(valid), .mem_read_m_i(rd), .mem_write_m_i(wr),
        .funct3_m_i(f3), .alu_result_m_i(addr), .write_data_m_i(wd),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(maddr), .dmem_be_o(be),
        .dmem_wdata_o(mwdata), .dmem_ack_i(ack), .dmem_rdata_i(rdata),
        .read_data_m_o(rdout), .stall_o(stall), .fault_o(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) req_prev = 0;
        else begin
            if (req && !req_prev) begin
                if (req_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    cur = req_q.pop_front();
                    chk("req_addr", maddr, cur.addr);
                    chk("req_be", {28'b0, be}, {28'b0, cur.be});
                    chk("req_wdata", mwdata, cur.wdata);
                    chk("req_we", {31'b0, we}, {31'b0, cur.we});
                end
                chk("busy_stall", {31'b0, stall}, 1);
            end else if (req) begin
                chk("hold_addr", maddr, cur.addr);
                chk("hold_be", {28'b0, be}, {28'b0, cur.be});
                chk("hold_wdata", mwdata, cur.wdata);
                chk("busy_stall", {31'b0, stall}, 1);
            end else if (req_prev) begin
                chk("done_stall", {31'b0, stall}, 0);
                if (!cur.we) begin
                    if (rd_q.size() == 0) chk("unexpected_load_done", 1, 0);
                    else chk("load_data", rdout, rd_q.pop_front());
                end
            end
            if (fault) begin
                if (flt_q.size() == 0) chk("unexpected_fault", 1, 0);
                else begin
                    chk("fault_rdata_held", rdout, flt_q.pop_front());
                    chk("fault_no_req", {31'b0, req}, 0);
                    chk("fault_stall", {31'b0, stall}, 0);
                end
            end
            req_prev = req;
        end
    end

    task automatic run(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] mem, input int dly);
        @(posedge clk); #1;
        valid = 1; rd = r; wr = w; f3 = f; addr = a; wd = d;
        @(posedge clk); #1;
        repeat (dly) begin @(posedge clk); #1; end
        ack = 1; rdata = mem;
        @(posedge clk); #1;
        ack = 0;
        @(posedge clk); #1;
        valid = 0; rd = 0; wr = 0;
    endtask

    task automatic load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] mem,
                        input logic [3:0] ebe, input logic [31:0] exp);
        req_q.push_back('{a & 32'hFFFF_FFFC, ebe, 32'h0, 1'b0});
        rd_q.push_back(exp);
        last_rd = exp;
        run(1, 0, f, a, 32'h0, mem, 0);
    endtask

    task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] ebe, input logic [31:0] ew, input int dly);
        req_q.push_back('{a & 32'hFFFF_FFFC, ebe, ew, 1'b1});
        run(0, 1, f, a, d, 32'h0, dly);
    endtask

    task automatic bad_access(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a);
        flt_q.push_back(last_rd);
        @(posedge clk); #1;
        valid = 1; rd = r; wr = w; f3 = f; addr = a;
        @(posedge clk); #1;
        valid = 0; rd = 0; wr = 0;
    endtask

    initial begin
        #12;
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_rdata", rdout, 0);
        chk("rst_addr", maddr, 0);
        chk("rst_be", {28'b0, be}, 0);
        chk("rst_wdata", mwdata, 0);
        rst_n = 1;
        load(3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        load(3'b000, 32'h103, 32'h80FF0000, 4'b1000, 32'hFFFFFF80);
        load(3'b100, 32'h103, 32'h80FF0000, 4'b1000, 32'h00000080);
        load(3'b101, 32'h102, 32'h80FF0000, 4'b1100, 32'h000080FF);
        load(3'b001, 32'h100, 32'h1234F00D, 4'b0011, 32'hFFFFF00D);
        store(3'b000, 32'h201, 32'h000000AB, 4'b0010, 32'hABABABAB, 0);
        store(3'b001, 32'h202, 32'h00001234, 4'b1100, 32'h12341234, 0);
        bad_access(1, 0, 3'b010, 32'h102);
        bad_access(1, 0, 3'b011, 32'h100);
        bad_access(1, 0, 3'b101, 32'h101);
        bad_access(1, 1, 3'b010, 32'h100);
        @(posedge clk); #1;
        valid = 1; ack = 1;
        #2;
        chk("nonmem_stall", {31'b0, stall}, 0);
        chk("nonmem_req", {31'b0, req}, 0);
        @(posedge clk); #1;
        chk("stray_ack_req", {31'b0, req}, 0);
        valid = 0; ack = 0;
        store(3'b010, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 5);
        req_q.push_back('{32'h100, 4'b1111, 32'h0, 1'b0});
        @(posedge clk); #1;
        valid = 1; rd = 1; f3 = 3'b010; addr = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0; valid = 0; rd = 0;
        #1;
        chk("midrst_req", {31'b0, req}, 0);
        chk("midrst_stall", {31'b0, stall}, 0);
        chk("midrst_addr", maddr, 0);
        @(posedge clk); #1;
        rst_n = 1;
        last_rd = 0;
        load(3'b010, 32'h104, 32'h12345678, 4'b1111, 32'h12345678);
        repeat (3) @(posedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("flt_q_drained", flt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
